// File: rtl/seq_pattern_pkg.sv
// Shared mode encodings and default constants for the sequence pattern generator.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  // Galois feedback mask giving a maximal-length 8-bit sequence.
  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state and period-wrap computation for all four sequence modes.
module seq_next_state
  import seq_pattern_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STEP      = 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS)
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] origin,
  output logic [WIDTH-1:0] next_state,
  output logic             wrap
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  // One extra bit so an UP step past the top of the range is still seen as exceeding limit.
  logic [WIDTH:0] up_sum;
  assign up_sum = {1'b0, state} + STEP_W;

  // Select the successor of the current state under the requested mode.
  always_comb begin
    next_state = state;
    wrap       = 1'b0;
    unique case (mode)
      MODE_UP: begin
        if (up_sum > {1'b0, limit}) begin
          next_state = '0;
          wrap       = 1'b1;
        end else begin
          next_state = up_sum[WIDTH-1:0];
        end
      end
      MODE_DOWN: begin
        if ({1'b0, state} < STEP_W) begin
          next_state = limit;
          wrap       = 1'b1;
        end else begin
          next_state = state - STEP_W[WIDTH-1:0];
        end
      end
      MODE_GRAY: begin
        // A state already past a lowered limit also restarts the period.
        if (state >= limit) begin
          next_state = '0;
          wrap       = 1'b1;
        end else begin
          next_state = state + WIDTH'(1);
        end
      end
      MODE_LFSR: begin
        // All-zero is the LFSR lockup state; escape to 1 without flagging a wrap.
        if (state == '0) begin
          next_state = WIDTH'(1);
        end else begin
          next_state = (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
          wrap       = (next_state == origin);
        end
      end
      default: begin
        next_state = state;
      end
    endcase
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Sequence pattern generator: UP/DOWN/GRAY/LFSR sequences behind a valid/ready handshake.
module seq_pattern_gen
  import seq_pattern_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STEP      = 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             wrap
);

  mode_e            mode_in;
  mode_e            mode_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] origin_q;
  logic             valid_q;
  logic             wrap_q;
  logic [WIDTH-1:0] nxt_state;
  logic             nxt_wrap;
  logic             xfer;
  logic             lockup;

  assign mode_in = mode_e'(mode);
  assign xfer    = valid_q & ready;
  assign lockup  = (mode_in == MODE_LFSR) && (state_q == '0);

  seq_next_state #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_next_state (
    .mode      (mode_in),
    .state     (state_q),
    .limit     (limit),
    .origin    (origin_q),
    .next_state(nxt_state),
    .wrap      (nxt_wrap)
  );

  // State, origin, handshake and wrap registers; load flushes and outranks a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RESET_VAL;
      origin_q <= RESET_VAL;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= MODE_UP;
    end else if (load) begin
      state_q  <= seed;
      origin_q <= seed;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= mode_in;
    end else begin
      valid_q <= enable | (valid_q & ~ready);
      wrap_q  <= xfer & nxt_wrap;
      if (xfer) begin
        state_q <= nxt_state;
        mode_q  <= mode_in;
        // Leaving lockup re-anchors the LFSR period at 1 so a later wrap is still reported.
        if (lockup) begin
          origin_q <= WIDTH'(1);
        end
      end else if (!valid_q) begin
        // Nothing is offered, so the output encoding may track the mode freely.
        mode_q <= mode_in;
      end
    end
  end

  assign data  = (mode_q == MODE_GRAY) ? (state_q ^ (state_q >> 1)) : state_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data and state width in bits (range 4..32).
REQ-002 SHALL have parameter STEP, default 1: UP/DOWN increment magnitude (1..2^WIDTH-1).
REQ-003 SHALL have parameter LFSR_TAPS, default 8'hB8 (WIDTH bits): Galois feedback mask.
REQ-004 SHALL have parameter RESET_VAL, default 0: state value after reset.
REQ-005 SHALL have port clk  input  1  sole clock; all flops on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  run request.
REQ-008 SHALL have port mode  input  2  sequence mode: 0 UP, 1 DOWN, 2 GRAY, 3 LFSR.
REQ-009 SHALL have port limit  input  WIDTH  wrap bound for UP/DOWN/GRAY.
REQ-010 SHALL have port load  input  1  synchronous load/flush strobe.
REQ-011 SHALL have port seed  input  WIDTH  value loaded on load.
REQ-012 SHALL have port ready  input  1  downstream accepts data.
REQ-013 SHALL have port data  output  WIDTH  current sequence value.
REQ-014 SHALL have port valid  output  1  data is offered.
REQ-015 SHALL have port wrap  output  1  one-cycle period-completion flag.

Function
REQ-016 SHALL hold an internal WIDTH-bit state register; data = gray(state) in GRAY mode, else data = state; no combinational path from any input to data/valid/wrap.
REQ-017 SHALL compute valid_next = enable | (valid & ~ready): once raised, valid stays high until a transfer.
REQ-018 SHALL define a transfer as valid & ready at a rising edge; state advances only on a transfer; data SHALL remain stable while valid & ~ready.
REQ-019 UP: next = state+STEP computed in WIDTH+1 bits; if result > limit, next = 0 and wrap.
REQ-020 DOWN: if state < STEP, next = limit and wrap; else next = state-STEP.
REQ-021 GRAY: binary state increments by 1; if state == limit, next = 0 and wrap; data = state ^ (state>>1).
REQ-022 LFSR: next = (state>>1) ^ (state[0] ? LFSR_TAPS : 0); wrap when next equals the origin register (value set at last reset/load); limit ignored.
REQ-023 SHALL sample mode at each transfer; a mode change affects only the next advance, reinterpreting the existing state.
REQ-024 load SHALL have priority over transfer: state <= seed, origin <= seed, valid <= 0 that cycle (flush, deliberate handshake exception), wrap <= 0.
REQ-025 LFSR lockup: a zero state in LFSR mode (reset, load or mode switch) SHALL be replaced by 1 on the next transfer or load.
REQ-026 wrap SHALL be registered, high for exactly the one cycle in which the post-wrap value is first presented.
REQ-027 limit changes SHALL take effect at the next transfer; if state already exceeds limit in UP/GRAY, the next transfer wraps to 0.

Reset
REQ-028 On reset high, asynchronously: state = RESET_VAL, origin = RESET_VAL, valid = 0, wrap = 0, hence data = RESET_VAL (gray-encoded in GRAY mode).
REQ-029 Reset release SHALL take effect at the next rising edge; first valid rises one edge after enable is sampled high.

Structure
REQ-030 Package seq_pattern_pkg SHALL hold the mode encodings (MODE_UP, MODE_DOWN, MODE_GRAY, MODE_LFSR) and the default tap constant.
REQ-031 Next-state/wrap computation SHALL be a combinational sub-module seq_next_state; the top holds only registers and handshake.

Verification (WIDTH=8, STEP=1, taps 8'hB8)
REQ-032 Reset, mode UP, limit=5, enable=1, ready=1 -> data 0,1,2,3,4,5,0 on consecutive transfers; wrap high with the second 0 only.
REQ-033 UP run, ready=0 for 3 cycles while data=2 -> valid stays 1, data holds 2; ready=1 -> next data 3.
REQ-034 DOWN, limit=3, load seed=2 -> valid low one cycle, then data 2,1,0,3,2; wrap with the 3.
REQ-035 GRAY, limit=7 from reset -> data 00,01,03,02,06,07,05,04,00; wrap with the final 00.
REQ-036 LFSR, load seed=1 -> 255 distinct nonzero values, wrap on the 255th transfer (value 1); load seed=0 -> next value 1.
REQ-037 Assert reset mid-run between edges -> data=0, valid=0, wrap=0 immediately, without a clock edge.
